hazard_unit_mc: RTL

- Parametrised successor to the single-cycle hazard unit of the 5-stage RV32I pipeline with branch prediction.
- Adds a registered state machine for multi-cycle load-use bubbles and multi-cycle MUL/DIV occupancy of EX.
- Adds saturating stall-cycle and redirect performance counters.
- Sits beside the pipeline registers; drives every Stall*/Flush* and the EX forwarding muxes.

---
 rtl/hazard_unit_mc.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32I pipeline: priority stall/flush decode,
// multi-cycle load-use and MUL/DIV wait states, EX forwarding and perf counters.
module hazard_unit_mc #(
    parameter int unsigned LOAD_USE_LAT = 1,
    parameter int unsigned MDU_LAT      = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned CTR_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ICacheMiss,
    input  logic             DCacheMiss,
    input  logic             BranchE,
    input  logic             PredictedE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic             MulDivE,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       RegReadE,
    input  logic             MemToRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             FlushF,
    output logic             StallD,
    output logic             FlushD,
    output logic             StallE,
    output logic             FlushE,
    output logic             StallM,
    output logic             FlushM,
    output logic             StallW,
    output logic             FlushW,
    output logic [1:0]       Forward1E,
    output logic [1:0]       Forward2E,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] RedirCnt
);

    localparam logic [CTR_W-1:0] LD_INIT  = CTR_W'(LOAD_USE_LAT - 1);
    localparam logic [CTR_W-1:0] MDU_INIT = CTR_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDWAIT  = 2'd1,
        MDUWAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    // Bit order {F, D, E, M, W}
    logic [4:0] stall_v, flush_v;
    logic       miss, redirect, load_use, redir_fire;

    assign miss     = ICacheMiss | DCacheMiss;
    assign redirect = (BranchE ^ PredictedE) | JalrE;
    assign load_use = MemToRegE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // Priority decode of stall/flush and next wait state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_v    = 5'b00000;
        flush_v    = 5'b00000;
        redir_fire = 1'b0;
        if (!rst_n) begin
            flush_v = 5'b11111;
        end else if (miss) begin
            stall_v = 5'b11111;
        end else if (state_q == LDWAIT) begin
            stall_v = 5'b11000;
            flush_v = 5'b00100;
            if (cnt_q <= CTR_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CTR_W'(1);
            end
        end else if (state_q == MDUWAIT) begin
            stall_v = 5'b11100;
            flush_v = 5'b00010;
            if (cnt_q <= CTR_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CTR_W'(1);
            end
        end else if (redirect) begin
            flush_v    = 5'b01100;
            redir_fire = 1'b1;
        end else if (MulDivE && (MDU_LAT > 1)) begin
            stall_v = 5'b11100;
            flush_v = 5'b00010;
            state_d = MDUWAIT;
            cnt_d   = MDU_INIT;
        end else if (load_use) begin
            stall_v = 5'b11000;
            flush_v = 5'b00100;
            if (LOAD_USE_LAT > 1) begin
                state_d = LDWAIT;
                cnt_d   = LD_INIT;
            end
        end else if (JalD) begin
            flush_v = 5'b01000;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (stall_v[4] && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redir_fire && (redir_cnt_q != CNT_MAX)) begin
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used);
        if (used && RegWriteM && (RdM == rs) && (RdM != 5'd0)) begin
            return 2'b10;
        end
        if (used && RegWriteW && (RdW == rs) && (RdW != 5'd0)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign Forward1E = rst_n ? fwd_sel(Rs1E, RegReadE[1]) : 2'b00;
    assign Forward2E = rst_n ? fwd_sel(Rs2E, RegReadE[0]) : 2'b00;

    assign {StallF, StallD, StallE, StallM, StallW} = stall_v;
    assign {FlushF, FlushD, FlushE, FlushM, FlushW} = flush_v;
    assign Busy     = (state_q != RUN);
    assign StallCnt = stall_cnt_q;
    assign RedirCnt = redir_cnt_q;

endmodule
